// File: rtl/mem_arbiter_rr3.sv
// Three-way SDRAM port arbiter (CPU / DMA / MCGA): round-robin with an MCGA urgent
// override, registered acks and read data, sticky ack-timeout flag.
module mem_arbiter_rr3 #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] cpu_m_addr,
  input  logic [15:0] cpu_m_data_out,
  output logic [15:0] cpu_m_data_in,
  input  logic        cpu_m_access,
  output logic        cpu_m_ack,
  input  logic        cpu_m_wr_en,
  input  logic [1:0]  cpu_m_bytesel,
  input  logic [19:1] dma_m_addr,
  input  logic [15:0] dma_m_data_out,
  output logic [15:0] dma_m_data_in,
  input  logic        dma_m_access,
  output logic        dma_m_ack,
  input  logic        dma_m_wr_en,
  input  logic [1:0]  dma_m_bytesel,
  input  logic [19:1] mcga_m_addr,
  input  logic [15:0] mcga_m_data_out,
  output logic [15:0] mcga_m_data_in,
  input  logic        mcga_m_access,
  output logic        mcga_m_ack,
  input  logic        mcga_m_wr_en,
  input  logic [1:0]  mcga_m_bytesel,
  input  logic        mcga_urgent,
  output logic [19:1] sdram_m_addr,
  output logic [15:0] sdram_m_data_out,
  input  logic [15:0] sdram_m_data_in,
  output logic        sdram_m_access,
  input  logic        sdram_m_ack,
  output logic        sdram_m_wr_en,
  output logic [1:0]  sdram_m_bytesel,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;
  localparam logic [1:0] OWN_MCGA = 2'b11;

  state_t           state, state_nxt;
  logic [1:0]       owner_nxt;
  logic [1:0]       last_srv;   // last round-robin winner; NONE after reset so CPU goes first
  logic [1:0]       pick_rr;
  logic             urgent_hit;
  logic             urgent_grant;
  logic [CNT_W-1:0] cnt;

  assign urgent_hit = mcga_urgent & mcga_m_access;

  always_comb begin
    pick_rr = OWN_NONE;
    case (last_srv)
      OWN_CPU: begin
        if      (dma_m_access)  pick_rr = OWN_DMA;
        else if (mcga_m_access) pick_rr = OWN_MCGA;
        else if (cpu_m_access)  pick_rr = OWN_CPU;
      end
      OWN_DMA: begin
        if      (mcga_m_access) pick_rr = OWN_MCGA;
        else if (cpu_m_access)  pick_rr = OWN_CPU;
        else if (dma_m_access)  pick_rr = OWN_DMA;
      end
      default: begin
        if      (cpu_m_access)  pick_rr = OWN_CPU;
        else if (dma_m_access)  pick_rr = OWN_DMA;
        else if (mcga_m_access) pick_rr = OWN_MCGA;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (urgent_hit) begin
          state_nxt = GRANT;
          owner_nxt = OWN_MCGA;
        end else if (pick_rr != OWN_NONE) begin
          state_nxt = GRANT;
          owner_nxt = pick_rr;
        end
      end
      GRANT: if (sdram_m_ack) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= OWN_NONE;
      last_srv       <= OWN_NONE;
      urgent_grant   <= 1'b0;
      cnt            <= '0;
      timeout_err    <= 1'b0;
      cpu_m_ack      <= 1'b0;
      dma_m_ack      <= 1'b0;
      mcga_m_ack     <= 1'b0;
      cpu_m_data_in  <= '0;
      dma_m_data_in  <= '0;
      mcga_m_data_in <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cpu_m_ack  <= 1'b0;
      dma_m_ack  <= 1'b0;
      mcga_m_ack <= 1'b0;
      if (state == IDLE) urgent_grant <= urgent_hit;
      if (state == GRANT) begin
        if (sdram_m_ack) begin
          cnt <= '0;
          // urgent grants leave the rotation untouched so skipped requesters keep their turn
          if (!urgent_grant) last_srv <= owner;
          case (owner)
            OWN_CPU:  begin cpu_m_ack  <= 1'b1; cpu_m_data_in  <= sdram_m_data_in; end
            OWN_DMA:  begin dma_m_ack  <= 1'b1; dma_m_data_in  <= sdram_m_data_in; end
            OWN_MCGA: begin mcga_m_ack <= 1'b1; mcga_m_data_in <= sdram_m_data_in; end
            default: ;
          endcase
        end else begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
        end
      end
    end
  end

  assign sdram_m_access = (state == GRANT);

  always_comb begin
    sdram_m_addr     = '0;
    sdram_m_data_out = '0;
    sdram_m_wr_en    = 1'b0;
    sdram_m_bytesel  = '0;
    case (owner)
      OWN_CPU: begin
        sdram_m_addr = cpu_m_addr;  sdram_m_data_out = cpu_m_data_out;
        sdram_m_wr_en = cpu_m_wr_en; sdram_m_bytesel = cpu_m_bytesel;
      end
      OWN_DMA: begin
        sdram_m_addr = dma_m_addr;  sdram_m_data_out = dma_m_data_out;
        sdram_m_wr_en = dma_m_wr_en; sdram_m_bytesel = dma_m_bytesel;
      end
      OWN_MCGA: begin
        sdram_m_addr = mcga_m_addr;  sdram_m_data_out = mcga_m_data_out;
        sdram_m_wr_en = mcga_m_wr_en; sdram_m_bytesel = mcga_m_bytesel;
      end
      default: ;
    endcase
  end

endmodule
